// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, SPI mode encodings and helpers for the SPI master
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    HOLD
  } state_t;

  // Mode encodings as {cpol, cpha}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period divider producing sclk and its leading/trailing edge strobes
module spi_clk_gen #(
  parameter int DIV_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 toggle_en,
  input  logic                 idle_level,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 sclk
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick       = run && (cnt == div);
  // An edge is leading when sclk is about to leave its idle level
  assign lead_edge  = tick && toggle_en && (sclk == cpol);
  assign trail_edge = tick && toggle_en && (sclk != cpol);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (!run || tick) cnt <= '0;
      else              cnt <= cnt + 1'b1;

      if (!run)                   sclk <= idle_level;
      else if (toggle_en && tick) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master: FSM, shifters and chip-select logic
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 12,
  parameter int NUM_SS     = 4,
  parameter int SS_IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [SS_IDX_W-1:0]   ss_sel,
  input  logic                  cs_hold,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     ss_n
);

  localparam int EW = clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  state_t                state, state_d;
  spi_mode_t             mode_q;
  logic                  cpol_q, cpha_q, lsb_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh;
  logic [EW-1:0]         edge_cnt;
  logic                  tick, lead_edge, trail_edge;
  logic                  run, accept, last_edge, sample_en, shift_en, idle_level;

  assign {cpol_q, cpha_q} = mode_q;
  assign run        = (state == LEAD) || (state == XFER) || (state == TRAIL);
  assign accept     = start && ((state == IDLE) || (state == HOLD));
  assign last_edge  = (edge_cnt == LAST_EDGE);
  assign sample_en  = cpha_q ? trail_edge : lead_edge;
  assign shift_en   = cpha_q ? lead_edge : (trail_edge && !last_edge);
  assign idle_level = (state == HOLD && !start) ? cpol_q : cpol;

  function automatic logic head(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v,
                                                    input logic lsb);
    return lsb ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_IDX_W-1:0] idx);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (idx == SS_IDX_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .toggle_en (state == XFER),
    .idle_level(idle_level),
    .cpol      (cpol_q),
    .div       (div_q),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .sclk      (sclk)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = LEAD;
      LEAD:    if (tick) state_d = XFER;
      XFER:    if (tick && last_edge) state_d = TRAIL;
      TRAIL:   if (tick) state_d = cs_hold ? HOLD : IDLE;
      HOLD:    if (start) state_d = LEAD;
               else if (!cs_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      mosi     <= 1'b1;
      ss_n     <= '1;
      mode_q   <= MODE0;
      lsb_q    <= 1'b0;
      div_q    <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;

      if (state != XFER) edge_cnt <= '0;
      else if (tick)     edge_cnt <= edge_cnt + 1'b1;

      if (accept) begin
        mode_q <= spi_mode_t'({cpol, cpha});
        lsb_q  <= lsb_first;
        div_q  <= clk_div;
        busy   <= 1'b1;
        if (state == IDLE) ss_n <= ss_decode(ss_sel);
        // CPHA=0 must present the first bit before the first sampling edge
        if (!cpha) begin
          mosi  <= head(tx_data, lsb_first);
          tx_sh <= advance(tx_data, lsb_first);
        end else begin
          mosi  <= 1'b1;
          tx_sh <= tx_data;
        end
      end

      if (sample_en) begin
        rx_sh <= lsb_q ? {miso, rx_sh[DATA_WIDTH-1:1]} : {rx_sh[DATA_WIDTH-2:0], miso};
      end

      if (shift_en) begin
        mosi  <= head(tx_sh, lsb_q);
        tx_sh <= advance(tx_sh, lsb_q);
      end

      if (state == TRAIL && tick) begin
        done    <= 1'b1;
        rx_data <= rx_sh;
        busy    <= 1'b0;
        mosi    <= 1'b1;
        if (!cs_hold) ss_n <= '1;
      end

      if (state == HOLD && !start && !cs_hold) ss_n <= '1;
    end
  end

endmodule
